// File: rtl/io_wait_ctrl.sv
// rtl/io_wait_ctrl.sv - Z8S180 I/O wait-state controller with peripheral req/ack handshake
// Optional timeout path enabled by defining IO_WAIT_TIMEOUT_EN.
module io_wait_ctrl #(
    parameter logic [7:0]  SLOW_BASE = 8'h40,
    parameter logic [7:0]  SLOW_MASK = 8'hF0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic       phi,
    input  logic       reset,
    input  logic       iorq,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rdata_oe,
    output logic       wait_out,
    output logic       dev_sel,
    output logic       dev_we,
    output logic [3:0] dev_addr,
    output logic [7:0] dev_wdata,
    input  logic [7:0] dev_rdata,
    input  logic       dev_ack,
    output logic       timeout,
    input  logic       timeout_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    // arm_q is set once iorq has been seen low after reset, so an iorq that
    // is already high when reset releases cannot masquerade as a fresh edge.
    logic       arm_q, arm_d;
    logic       rd_q, rd_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       match;
    logic       start;

`ifdef IO_WAIT_TIMEOUT_EN
    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       tc;
    assign tc = (cnt_q == TC_VAL);
`else
    localparam logic [7:0] unused_timeout = 8'(TIMEOUT);
    logic unused_clr;
    assign unused_clr = timeout_clr;
`endif

    // Rising-edge detect of iorq and address window match
    always_comb begin
        sync_d = {sync_q[0], iorq};
        arm_d  = arm_q | ~iorq;
        match  = ((addr & SLOW_MASK) == SLOW_BASE);
        start  = (sync_q == 2'b01) && arm_q && iorq && match;
    end

    // Next-state and datapath updates for the handshake FSM
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef IO_WAIT_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q & ~timeout_clr;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    rd_d    = rd;
                    addr_d  = addr[3:0];
                    wdata_d = wdata;
`ifdef IO_WAIT_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            REQ: begin
`ifdef IO_WAIT_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                // An aborted cycle drops straight back without touching rdata;
                // ack is checked before terminal count so a late ack still wins.
                if (!iorq) begin
                    state_d = IDLE;
                end else if (dev_ack) begin
                    if (rd_q) begin
                        rdata_d = dev_rdata;
                    end
                    state_d = HOLD;
                end
`ifdef IO_WAIT_TIMEOUT_EN
                else if (tc) begin
                    rdata_d   = 8'hFF;
                    timeout_d = 1'b1;
                    state_d   = HOLD;
                end
`endif
            end
            HOLD: begin
                if (!iorq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b00;
            arm_q     <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 4'h0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
`ifdef IO_WAIT_TIMEOUT_EN
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            arm_q     <= arm_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
`ifdef IO_WAIT_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Bus and peripheral outputs decoded from state; WAIT rises combinationally on start
    always_comb begin
        dev_sel  = (state_q == REQ);
        dev_we   = (state_q == REQ) && !rd_q;
        wait_out = (state_q == REQ) || start;
        rdata_oe = (state_q == HOLD) && rd_q && iorq;
    end

    assign rdata     = rdata_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
`ifdef IO_WAIT_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
